// File: rtl/layer_dense_stream_pkg.sv
// Shared definitions for layer_dense_stream: default sizes, FSM state encodings, width helper.
// The optional bias path is controlled by the DENSE_BIAS_EN macro in the design files.
package layer_dense_stream_pkg;

  localparam int DEF_BIT_DATA = 8;
  localparam int DEF_BIT_ACC  = 32;
  localparam int DEF_NIN      = 128;
  localparam int DEF_NOUT     = 10;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam logic [1:0] ST_ACC    = 2'd0;
  localparam logic [1:0] ST_SCALE  = 2'd1;
  localparam logic [1:0] ST_ARGMAX = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  function automatic int bit_sh(input int bit_acc, input int bit_data);
    return $clog2(bit_acc - bit_data);
  endfunction

endpackage

// File: rtl/layer_dense_stream_if.sv
// Sample/weight/result bus for layer_dense_stream; the bias_load/bias pair exists only
// when DENSE_BIAS_EN is defined.
interface layer_dense_stream_if
  import layer_dense_stream_pkg::*;
#(
  parameter int BIT_DATA = DEF_BIT_DATA,
  parameter int BIT_ACC  = DEF_BIT_ACC,
  parameter int NIN      = DEF_NIN,
  parameter int NOUT     = DEF_NOUT,
  parameter int BIT_SH   = bit_sh(BIT_ACC, BIT_DATA),
  parameter int AW       = $clog2(NIN),
  parameter int OW       = $clog2(NOUT)
);
  logic                       load;
  logic [AW-1:0]              w_addr_in;
  logic [OW-1:0]              w_addr_out;
  logic signed [BIT_DATA-1:0] w;
  logic signed [BIT_DATA-1:0] x;
  logic                       x_valid;
  logic                       x_ready;
  logic [BIT_SH-1:0]          scale;
  logic signed [BIT_DATA-1:0] z;
  logic [OW-1:0]              index;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;
`ifdef DENSE_BIAS_EN
  logic                       bias_load;
  logic signed [BIT_ACC-1:0]  bias;
`endif

  modport master (
    output load, w_addr_in, w_addr_out, w, x, x_valid, scale, out_ready,
`ifdef DENSE_BIAS_EN
    output bias_load, bias,
`endif
    input  x_ready, z, index, out_valid, busy
  );

  modport slave (
    input  load, w_addr_in, w_addr_out, w, x, x_valid, scale, out_ready,
`ifdef DENSE_BIAS_EN
    input  bias_load, bias,
`endif
    output x_ready, z, index, out_valid, busy
  );
endinterface

// File: rtl/layer_dense_stream_mac_lane.sv
// One MAC lane: weight column storage, accumulator with clear-on-first-sample, shift+saturate.
// With DENSE_BIAS_EN the accumulator is seeded from a per-lane bias register.
module layer_dense_stream_mac_lane
  import layer_dense_stream_pkg::*;
#(
  parameter int BIT_DATA = DEF_BIT_DATA,
  parameter int BIT_ACC  = DEF_BIT_ACC,
  parameter int NIN      = DEF_NIN,
  parameter int BIT_SH   = bit_sh(BIT_ACC, BIT_DATA),
  parameter int AW       = $clog2(NIN)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       w_we,
  input  logic [AW-1:0]              w_addr,
  input  logic signed [BIT_DATA-1:0] w,
  input  logic                       acc_en,
  input  logic                       first,
  input  logic [AW-1:0]              rd_addr,
  input  logic signed [BIT_DATA-1:0] x,
  input  logic                       scale_en,
  input  logic [BIT_SH-1:0]          scale,
`ifdef DENSE_BIAS_EN
  input  logic                       bias_we,
  input  logic signed [BIT_ACC-1:0]  bias,
`endif
  output logic signed [BIT_DATA-1:0] s
);
  localparam logic signed [BIT_ACC-1:0] SAT_MAX = {{(BIT_ACC-BIT_DATA+1){1'b0}}, {(BIT_DATA-1){1'b1}}};
  localparam logic signed [BIT_ACC-1:0] SAT_MIN = {{(BIT_ACC-BIT_DATA+1){1'b1}}, {(BIT_DATA-1){1'b0}}};

  logic signed [BIT_DATA-1:0]   w_mem_r [NIN];
  logic signed [BIT_ACC-1:0]    acc_r;
  logic signed [BIT_ACC-1:0]    base_s;
  logic signed [BIT_ACC-1:0]    prod_ext_s;
  logic signed [BIT_ACC-1:0]    shifted_s;
  logic signed [2*BIT_DATA-1:0] prod_s;
`ifdef DENSE_BIAS_EN
  logic signed [BIT_ACC-1:0]    bias_r;
`endif

  function automatic logic signed [BIT_DATA-1:0] sat(input logic signed [BIT_ACC-1:0] v);
    logic signed [BIT_DATA-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[BIT_DATA-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[BIT_DATA-1:0];
    else                  r = v[BIT_DATA-1:0];
    return r;
  endfunction

  assign prod_s     = (2*BIT_DATA)'(x) * (2*BIT_DATA)'(w_mem_r[rd_addr]);
  assign prod_ext_s = BIT_ACC'(prod_s);
  assign shifted_s  = acc_r >>> scale;

  // Accumulator seed: the first sample of a frame discards the previous frame's sum.
  always_comb begin
    if (first) begin
`ifdef DENSE_BIAS_EN
      base_s = bias_r;
`else
      base_s = {BIT_ACC{1'b0}};
`endif
    end else begin
      base_s = acc_r;
    end
  end

  // Weight column write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NIN; i++) w_mem_r[i] <= {BIT_DATA{1'b0}};
    end else if (w_we) begin
      w_mem_r[w_addr] <= w;
    end
  end

`ifdef DENSE_BIAS_EN
  // Bias register write port.
  always_ff @(posedge clock) begin
    if (reset)        bias_r <= {BIT_ACC{1'b0}};
    else if (bias_we) bias_r <= bias;
  end
`endif

  // Accumulate on accepted samples, capture the scaled result in the scale cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_r <= {BIT_ACC{1'b0}};
      s     <= {BIT_DATA{1'b0}};
    end else begin
      if (acc_en)   acc_r <= base_s + prod_ext_s;
      if (scale_en) s     <= sat(shifted_s);
    end
  end
endmodule

// File: rtl/layer_dense_stream.sv
// Dense layer: NOUT MAC lanes over an NIN-sample frame, scale/saturate, then a lane-serial
// argmax emitting (z, index). Defining DENSE_BIAS_EN adds per-lane bias seeding.
module layer_dense_stream
  import layer_dense_stream_pkg::*;
#(
  parameter int BIT_DATA = DEF_BIT_DATA,
  parameter int BIT_ACC  = DEF_BIT_ACC,
  parameter int NIN      = DEF_NIN,
  parameter int NOUT     = DEF_NOUT,
  parameter int BIT_SH   = bit_sh(BIT_ACC, BIT_DATA)
) (
  input logic                 clock,
  input logic                 reset,
  layer_dense_stream_if.slave dense
);
  localparam int AW = $clog2(NIN);
  localparam int OW = $clog2(NOUT);
  localparam logic [AW-1:0] CNT_LAST  = AW'(NIN - 1);
  localparam logic [OW-1:0] LANE_LAST = OW'(NOUT - 1);
  localparam logic [AW:0]   NIN_W     = (AW+1)'(NIN);

  logic [1:0]                 state_r;
  logic [AW-1:0]              cnt_r;
  logic [OW-1:0]              lane_r;
  logic [BIT_SH-1:0]          scale_r;
  logic signed [BIT_DATA-1:0] best_r, z_r, sel_s, best_nx_s;
  logic [OW-1:0]              best_idx_r, index_r, idx_nx_s;
  logic                       out_valid_r;
  logic                       idle_s, x_ready_s, accept_s, w_in_ok_s;
  logic signed [BIT_DATA-1:0] lane_s [NOUT];

  assign idle_s    = (state_r == ST_ACC) && (cnt_r == {AW{1'b0}});
  assign x_ready_s = (state_r == ST_ACC) && !dense.load;
  assign accept_s  = dense.x_valid && x_ready_s;
  assign w_in_ok_s = idle_s && ({1'b0, dense.w_addr_in} < NIN_W);

  for (genvar k = 0; k < NOUT; k++) begin : g_lane
    logic lane_hit_s;
    assign lane_hit_s = (dense.w_addr_out == OW'(k));

    layer_dense_stream_mac_lane #(
      .BIT_DATA(BIT_DATA), .BIT_ACC(BIT_ACC), .NIN(NIN), .BIT_SH(BIT_SH), .AW(AW)
    ) u_lane (
      .clock    (clock),
      .reset    (reset),
      .w_we     (dense.load && w_in_ok_s && lane_hit_s),
      .w_addr   (dense.w_addr_in),
      .w        (dense.w),
      .acc_en   (accept_s),
      .first    (cnt_r == {AW{1'b0}}),
      .rd_addr  (cnt_r),
      .x        (dense.x),
      .scale_en (state_r == ST_SCALE),
      .scale    (scale_r),
`ifdef DENSE_BIAS_EN
      .bias_we  (dense.bias_load && idle_s && lane_hit_s),
      .bias     (dense.bias),
`endif
      .s        (lane_s[k])
    );
  end

  // Argmax step: lane 0 seeds the scan, later lanes replace it only when strictly larger.
  always_comb begin
    sel_s = {BIT_DATA{1'b0}};
    for (int k = 0; k < NOUT; k++) sel_s = (lane_r == OW'(k)) ? lane_s[k] : sel_s;
    if ((lane_r == {OW{1'b0}}) || (sel_s > best_r)) begin
      best_nx_s = sel_s;
      idx_nx_s  = lane_r;
    end else begin
      best_nx_s = best_r;
      idx_nx_s  = best_idx_r;
    end
  end

  // Frame FSM: accumulate, scale, argmax scan, hold result until consumed.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_ACC;
      cnt_r       <= {AW{1'b0}};
      lane_r      <= {OW{1'b0}};
      scale_r     <= {BIT_SH{1'b0}};
      best_r      <= {BIT_DATA{1'b0}};
      best_idx_r  <= {OW{1'b0}};
      z_r         <= {BIT_DATA{1'b0}};
      index_r     <= {OW{1'b0}};
      out_valid_r <= OFF;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (accept_s) begin
            if (cnt_r == {AW{1'b0}}) scale_r <= dense.scale;
            if (cnt_r == CNT_LAST) begin
              cnt_r   <= {AW{1'b0}};
              state_r <= ST_SCALE;
            end else begin
              cnt_r <= cnt_r + AW'(1'b1);
            end
          end
        end
        ST_SCALE: begin
          lane_r  <= {OW{1'b0}};
          state_r <= ST_ARGMAX;
        end
        ST_ARGMAX: begin
          best_r     <= best_nx_s;
          best_idx_r <= idx_nx_s;
          if (lane_r == LANE_LAST) begin
            z_r         <= best_nx_s;
            index_r     <= idx_nx_s;
            out_valid_r <= ON;
            state_r     <= ST_OUT;
          end else begin
            lane_r <= lane_r + OW'(1'b1);
          end
        end
        ST_OUT: begin
          if (dense.out_ready) begin
            out_valid_r <= OFF;
            state_r     <= ST_ACC;
          end
        end
        default: begin
          state_r     <= ST_ACC;
          cnt_r       <= {AW{1'b0}};
          out_valid_r <= OFF;
        end
      endcase
    end
  end

  assign dense.x_ready   = x_ready_s;
  assign dense.z         = z_r;
  assign dense.index     = index_r;
  assign dense.out_valid = out_valid_r;
  assign dense.busy      = !idle_s;
endmodule

// File: tb/tb_layer_dense_stream.sv
// Directed + randomized bench for layer_dense_stream (NIN=4, NOUT=3) against a frame-level model.
module tb_layer_dense_stream;
  import layer_dense_stream_pkg::*;

  localparam int BD   = 8;
  localparam int BA   = 32;
  localparam int NIN  = 4;
  localparam int NOUT = 3;
  localparam int BSH  = bit_sh(BA, BD);
  localparam int AW   = $clog2(NIN);
  localparam int OW   = $clog2(NOUT);
  localparam int SMAX = (1 << (BD - 1)) - 1;
  localparam int SMIN = -(1 << (BD - 1));

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  layer_dense_stream_if #(.BIT_DATA(BD), .BIT_ACC(BA), .NIN(NIN), .NOUT(NOUT)) bus_if ();
  layer_dense_stream #(.BIT_DATA(BD), .BIT_ACC(BA), .NIN(NIN), .NOUT(NOUT)) dut (
    .clock (clock),
    .reset (reset),
    .dense (bus_if.slave)
  );

  int wm [NIN][NOUT];
  int xs [NIN];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame result from the definition: dot products, shift, clamp, first maximum wins.
  function automatic void model(input int sc, output int z_e, output int i_e);
    int acc;
    int s;
    z_e = 0;
    i_e = 0;
    for (int k = 0; k < NOUT; k++) begin
      acc = 0;
      for (int i = 0; i < NIN; i++) acc += xs[i] * wm[i][k];
      s = acc >>> sc;
      if (s > SMAX) s = SMAX;
      else if (s < SMIN) s = SMIN;
      if (k == 0 || s > z_e) begin
        z_e = s;
        i_e = k;
      end
    end
  endfunction

  task automatic load_w(input int i, input int k, input int v);
    @(negedge clock);
    bus_if.load       = 1'b1;
    bus_if.w_addr_in  = AW'(i);
    bus_if.w_addr_out = OW'(k);
    bus_if.w          = BD'(v);
    @(posedge clock);
    #1;
    bus_if.load = 1'b0;
    if (k < NOUT) wm[i][k] = v;
  endtask

  task automatic run_frame(input string tag, input int sc, input bit argmax_load, input int hold,
                           input bit use_model, input int dz, input int di);
    int i;
    int guard;
    int n;
    int ez;
    int ei;
    bit ld;
    if (use_model) model(sc, ez, ei);
    else begin
      ez = dz;
      ei = di;
    end
    i = 0;
    guard = 0;
    while (i < NIN && guard < 100) begin
      @(negedge clock);
      guard++;
      ld = (i > 0) && ($urandom_range(0, 4) == 0);
      bus_if.scale      = BSH'(sc);
      bus_if.x          = BD'(xs[i]);
      bus_if.x_valid    = ($urandom_range(0, 3) != 0);
      bus_if.load       = ld;
      bus_if.w_addr_in  = AW'($urandom_range(0, NIN - 1));
      bus_if.w_addr_out = OW'($urandom_range(0, NOUT - 1));
      bus_if.w          = BD'($urandom);
      #1;
      chk({tag, "_x_ready"}, bus_if.x_ready, !ld);
      @(posedge clock);
      if (bus_if.x_valid && !ld) i++;
    end
    #1;
    bus_if.x_valid = 1'b0;
    bus_if.load    = 1'b0;
    chk({tag, "_accepted"}, i, NIN);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (argmax_load) begin
        bus_if.load       = (n == 1);
        bus_if.w_addr_in  = AW'(0);
        bus_if.w_addr_out = OW'(0);
        bus_if.w          = BD'(100);
      end
    end while (n < 40 && bus_if.out_valid !== 1'b1);
    bus_if.load = 1'b0;
    chk({tag, "_latency"}, n + 1, NOUT + 2);
    chk({tag, "_z"}, $signed(bus_if.z), ez);
    chk({tag, "_index"}, bus_if.index, ei);
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1;
      bus_if.x_valid = 1'b1;
      #1;
      chk({tag, "_hold_valid"}, bus_if.out_valid, 1);
      chk({tag, "_hold_z"}, $signed(bus_if.z), ez);
      chk({tag, "_hold_index"}, bus_if.index, ei);
      chk({tag, "_hold_x_ready"}, bus_if.x_ready, 0);
    end
    @(negedge clock);
    bus_if.x_valid   = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus_if.out_ready = 1'b0;
    chk({tag, "_consumed"}, bus_if.out_valid, 0);
    chk({tag, "_idle"}, bus_if.busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset             = 1'b1;
    bus_if.load       = 1'b0;
    bus_if.w_addr_in  = '0;
    bus_if.w_addr_out = '0;
    bus_if.w          = '0;
    bus_if.x          = '0;
    bus_if.x_valid    = 1'b0;
    bus_if.scale      = '0;
    bus_if.out_ready  = 1'b0;
`ifdef DENSE_BIAS_EN
    bus_if.bias_load  = 1'b0;
    bus_if.bias       = '0;
`endif
    for (int i = 0; i < NIN; i++) for (int k = 0; k < NOUT; k++) wm[i][k] = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_z", $signed(bus_if.z), 0);
    chk("rst_index", bus_if.index, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_x_ready", bus_if.x_ready, 1);

    for (int i = 0; i < NIN; i++) for (int k = 0; k < NOUT; k++) load_w(i, k, k + 1);
    for (int i = 0; i < NIN; i++) xs[i] = 1;
    run_frame("rows", 0, 1'b0, 5, 1'b0, 12, 2);
    run_frame("argmax_load", 0, 1'b1, 0, 1'b0, 12, 2);
    run_frame("after_argmax_load", 0, 1'b0, 0, 1'b0, 12, 2);

    for (int i = 0; i < NIN; i++) for (int k = 0; k < NOUT; k++) load_w(i, k, 1);
    for (int i = 0; i < NIN; i++) xs[i] = 5;
    run_frame("tie", 0, 1'b0, 0, 1'b0, 20, 0);

    for (int i = 0; i < NIN; i++) for (int k = 0; k < NOUT; k++) load_w(i, k, 127);
    for (int i = 0; i < NIN; i++) xs[i] = 127;
    run_frame("saturate", 0, 1'b0, 0, 1'b0, 127, 0);
    run_frame("shift9", 9, 1'b0, 0, 1'b0, 126, 0);

    for (int i = 0; i < NIN; i++) for (int k = 0; k < NOUT; k++) load_w(i, k, (k == 0) ? -1 : -2);
    for (int i = 0; i < NIN; i++) xs[i] = 10;
    load_w(0, NOUT, 77);
    run_frame("negative", 0, 1'b0, 0, 1'b0, -40, 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NIN; i++)
        for (int k = 0; k < NOUT; k++) load_w(i, k, int'($urandom_range(0, 255)) - 128);
      load_w(int'($urandom_range(0, NIN - 1)), NOUT, 55);
      for (int i = 0; i < NIN; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
      run_frame("random", int'($urandom_range(0, BA - BD - 1)), 1'b0,
                int'($urandom_range(0, 2)), 1'b1, 0, 0);
    end

    @(negedge clock);
    bus_if.x       = BD'(3);
    bus_if.x_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    bus_if.x_valid = 1'b0;
    chk("mid_frame_busy", bus_if.busy, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("mid_reset_out_valid", bus_if.out_valid, 0);
    chk("mid_reset_busy", bus_if.busy, 0);
    for (int i = 0; i < NIN; i++) for (int k = 0; k < NOUT; k++) wm[i][k] = 0;
    for (int i = 0; i < NIN; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
    run_frame("post_reset", 4, 1'b0, 0, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
